// File: rtl/sar_search8_pkg.sv
// Shared constants and state encoding for the sar_search8 successive-approximation engine.
// Optional feature macro: SAR_EARLY_EXIT_EN (consumed by sar_search8).
package sar_search8_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned IDX_W = 3;

  localparam logic [WIDTH-1:0] TRIAL_INIT = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/sar_search8_if.sv
// Handshake and comparator-side bus of sar_search8; slave is the engine, master drives start/flags.
interface sar_search8_if;
  import sar_search8_pkg::*;

  logic             start;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [WIDTH-1:0] trial;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (output start, gt, lt, eq,
                  input  trial, busy, done, result, err);

  modport slave  (input  start, gt, lt, eq,
                  output trial, busy, done, result, err);

endinterface

// File: rtl/sar_search8_step.sv
// Combinational SAR step: decides bit idx of trial from the comparator flags and sets bit idx-1.
module sar_step
  import sar_search8_pkg::*;
(
  input  logic [WIDTH-1:0] trial,
  input  logic [IDX_W-1:0] idx,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic [WIDTH-1:0] next_trial,
  output logic             flag_err
);

  // Non-one-hot flags are reported and resolved as "target below trial".
  always_comb begin
    flag_err   = !$onehot({gt, lt, eq});
    next_trial = trial;
    if (flag_err || lt) begin
      next_trial[idx] = 1'b0;
    end
    if (idx != '0) begin
      next_trial[idx - IDX_W'(1)] = 1'b1;
    end
  end

endmodule

// File: rtl/sar_search8.sv
// sar_search8: SAR search FSM driving a comparator trial operand and latching the recovered value.
// Optional feature macro: SAR_EARLY_EXIT_EN (finish as soon as the comparator reports eq).
module sar_search8
  import sar_search8_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  sar_search8_if.slave  bus
);

  state_t           state, state_n;
  logic [WIDTH-1:0] trial_q, trial_n;
  logic [WIDTH-1:0] result_q, result_n;
  logic [IDX_W-1:0] idx_q, idx_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             err_q, err_n;

  logic [WIDTH-1:0] step_trial;
  logic             step_err;
  logic             early_c;

  sar_step u_step (
    .trial      (trial_q),
    .idx        (idx_q),
    .gt         (bus.gt),
    .lt         (bus.lt),
    .eq         (bus.eq),
    .next_trial (step_trial),
    .flag_err   (step_err)
  );

`ifdef SAR_EARLY_EXIT_EN
  assign early_c = bus.eq && !step_err;
`else
  assign early_c = 1'b0;
`endif

  // State and registered outputs; an aborted search leaves the previous result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      trial_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (state == ST_SEARCH) begin
        result_q <= result_q;
      end else begin
        result_q <= '0;
      end
    end else begin
      state    <= state_n;
      trial_q  <= trial_n;
      idx_q    <= idx_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
      result_q <= result_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state;
    trial_n  = trial_q;
    idx_n    = idx_q;
    result_n = result_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = err_q;

    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_SEARCH;
          trial_n = TRIAL_INIT;
          idx_n   = IDX_W'(WIDTH - 1);
          err_n   = 1'b0;
          busy_n  = 1'b1;
        end
      end
      ST_SEARCH: begin
        if (step_err) begin
          err_n = 1'b1;
        end
        if (early_c || idx_q == '0) begin
          state_n  = ST_DONE;
          result_n = early_c ? trial_q : step_trial;
          trial_n  = '0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
        end else begin
          trial_n = step_trial;
          idx_n   = idx_q - IDX_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
        trial_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.trial  = trial_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sar_search8.sv
// Self-checking bench for sar_search8: a behavioural comparator around the DUT plus a trial/result scoreboard.
module tb_sar_search8;

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic [7:0] result;
    logic       err;
    int         done_cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] target;
  logic       force_bad;

  logic [7:0] trial_q[$];
  exp_t       exp_q[$];

  int n_checks;
  int n_fail;

  sar_search8_if bus ();

  sar_search8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational comparator: operand a is the target, operand b the DUT trial.
  assign bus.gt = force_bad ? 1'b1 : (target > bus.trial);
  assign bus.lt = force_bad ? 1'b1 : (target < bus.trial);
  assign bus.eq = force_bad ? 1'b0 : (target == bus.trial);

  // Reference binary search: queues the expected trial per compare cycle and the final outcome.
  function automatic void model_push(input logic [7:0] tgt, input int bad_cyc);
    logic [7:0] t;
    exp_t       e;
    int         c;
    t          = 8'h80;
    e.err      = 1'b0;
    e.result   = 8'h00;
    e.done_cyc = 9;
    for (int i = 7; i >= 0; i--) begin
      c = 8 - i;
      trial_q.push_back(t);
      if (c == bad_cyc) begin
        e.err = 1'b1;
        t[i]  = 1'b0;
      end else if (EARLY && tgt == t) begin
        e.result   = t;
        e.done_cyc = c + 1;
        exp_q.push_back(e);
        return;
      end else if (tgt < t) begin
        t[i] = 1'b0;
      end
      if (i > 0) t[i-1] = 1'b1;
    end
    e.result = t;
    exp_q.push_back(e);
  endfunction

  task automatic run_and_check(input string nm, input int bad_cyc, input int pa, input int pb);
    exp_t       e;
    logic [7:0] t_exp;
    bit         seen;
    int         extra_done;
    e = exp_q.pop_front();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    seen = 1'b0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      force_bad = (c == bad_cyc);
      bus.start = (c == pa || c == pb);
      if (bus.done) begin
        seen = 1'b1;
        n_checks++;
        if (c != e.done_cyc) begin
          n_fail++;
          $display("FAIL %s done_cycle: got %0d expected %0d", nm, c, e.done_cyc);
        end
        n_checks++;
        if (bus.result !== e.result || bus.err !== e.err || bus.busy !== 1'b0 || bus.trial !== 8'h00) begin
          n_fail++;
          $display("FAIL %s done_outputs: result=%h err=%b busy=%b trial=%h expected result=%h err=%b busy=0 trial=00",
                   nm, bus.result, bus.err, bus.busy, bus.trial, e.result, e.err);
        end
      end else begin
        t_exp = (trial_q.size() > 0) ? trial_q.pop_front() : 8'hxx;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.trial !== t_exp ||
            bus.err !== ((bad_cyc > 0 && c > bad_cyc) ? 1'b1 : 1'b0)) begin
          n_fail++;
          $display("FAIL %s cycle%0d: busy=%b trial=%h err=%b expected busy=1 trial=%h err=%b",
                   nm, c, bus.busy, bus.trial, bus.err, t_exp, (bad_cyc > 0 && c > bad_cyc));
        end
      end
      @(negedge clk);
    end
    force_bad = 1'b0;
    bus.start = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: done not seen within 12 cycles", nm);
    end
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trial !== 8'h00) begin
      n_fail++;
      $display("FAIL %s idle_after_done: busy=%b done=%b trial=%h expected 0 0 00", nm, bus.busy, bus.done, bus.trial);
    end
    extra_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done) extra_done++;
    end
    n_checks++;
    if (extra_done != 0) begin
      n_fail++;
      $display("FAIL %s extra_done: got %0d extra pulses expected 0", nm, extra_done);
    end
    trial_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.trial !== 8'h00 || bus.result !== 8'h00 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: trial=%h result=%h busy=%b done=%b err=%b expected all zero",
               bus.trial, bus.result, bus.busy, bus.done, bus.err);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    logic [7:0] seq [8];
    exp_t e;
    seq = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    target = 8'h00;
    foreach (seq[i]) trial_q.push_back(seq[i]);
    e.result = 8'h00; e.err = 1'b0; e.done_cyc = 9;
    exp_q.push_back(e);
    run_and_check("target_00", 0, 0, 0);
  endtask

  task automatic test_ff();
    logic [7:0] seq [8];
    exp_t e;
    seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF};
    target = 8'hFF;
    foreach (seq[i]) trial_q.push_back(seq[i]);
    e.result = 8'hFF; e.err = 1'b0; e.done_cyc = 9;
    exp_q.push_back(e);
    run_and_check("target_FF", 0, 0, 0);
  endtask

  task automatic test_early_exit();
    target = 8'h80;
    model_push(8'h80, 0);
    run_and_check("target_80", 0, 0, 0);
  endtask

  task automatic test_ignored_start();
    target = 8'h5A;
    model_push(8'h5A, 0);
    run_and_check("start_during_search", 0, 3, 5);
  endtask

  task automatic test_flag_err();
    target = 8'hC3;
    model_push(8'hC3, 4);
    run_and_check("flag_error", 4, 0, 0);
    target = 8'h21;
    model_push(8'h21, 0);
    run_and_check("err_cleared", 0, 0, 0);
  endtask

  task automatic test_reset_abort();
    logic [7:0] t_exp;
    int dones;
    target = 8'h5A;
    model_push(8'h5A, 0);
    run_and_check("prior_5A", 0, 0, 0);
    target = 8'h33;
    model_push(8'h33, 0);
    void'(exp_q.pop_front());
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      t_exp = trial_q.pop_front();
      n_checks++;
      if (bus.trial !== t_exp || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL abort_search cycle%0d: trial=%h busy=%b expected trial=%h busy=1", c, bus.trial, bus.busy, t_exp);
      end
      if (c == 5) rst = 1'b1;
      @(negedge clk);
    end
    rst = 1'b0;
    trial_q.delete();
    n_checks++;
    if (bus.trial !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.err !== 1'b0 || bus.result !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_state: trial=%h busy=%b done=%b err=%b result=%h expected 00 0 0 0 5A",
               bus.trial, bus.busy, bus.done, bus.err, bus.result);
    end
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    n_checks++;
    if (dones != 0 || bus.result !== 8'h5A) begin
      n_fail++;
      $display("FAIL abort_quiet: done/busy cycles=%0d result=%h expected 0 and 5A", dones, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    target = 8'h00;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 11; c++) begin
      if (c == 9) begin
        n_checks++;
        if (bus.done !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_done9: done=%b expected 1", bus.done);
        end
      end
      if (c == 10) begin
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.trial !== 8'h00) begin
          n_fail++;
          $display("FAIL b2b_idle10: busy=%b done=%b trial=%h expected 0 0 00", bus.busy, bus.done, bus.trial);
        end
      end
      if (c == 11) begin
        n_checks++;
        if (bus.busy !== 1'b1 || bus.trial !== 8'h80) begin
          n_fail++;
          $display("FAIL b2b_relaunch11: busy=%b trial=%h expected 1 80", bus.busy, bus.trial);
        end
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    ok = 1'b0;
    for (int k = 0; k < 12 && !ok; k++) begin
      if (bus.done) ok = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || bus.result !== 8'h00) begin
      n_fail++;
      $display("FAIL b2b_second: done_seen=%b result=%h expected 1 00", ok, bus.result);
    end
  endtask

  task automatic test_random();
    logic [7:0] tgt;
    for (int n = 0; n < 6; n++) begin
      tgt = 8'($urandom_range(0, 255));
      target = tgt;
      model_push(tgt, 0);
      n_checks++;
      if (exp_q[exp_q.size()-1].result !== tgt) begin
        n_fail++;
        $display("FAIL model_sanity: model result=%h target=%h", exp_q[exp_q.size()-1].result, tgt);
      end
      run_and_check("random", 0, 0, 0);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    target    = 8'h00;
    force_bad = 1'b0;
    bus.start = 1'b0;
    test_reset();
    test_zero();
    test_ff();
    test_early_exit();
    test_ignored_start();
    test_flag_err();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_search8.md
# sar_search8

Successive-approximation search engine that drives the trial operand of an external 8-bit magnitude comparator and consumes its gt/lt/eq flags to recover an unknown 8-bit target value. It sits on the opposite side of the comparator from the target source: comparator operand a is the target, operand b is this block's `trial`. A start/busy/done handshake with a registered result makes it usable as the front end of threshold-search and ADC-style loops.

## Interface
- `WIDTH`, 8, operand/result width; the design is verified at 8 only.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a search; sampled only in IDLE.
- `gt`  in  1  comparator flag: target > trial.
- `lt`  in  1  comparator flag: target < trial.
- `eq`  in  1  comparator flag: target == trial.
- `trial`  out  WIDTH  registered operand driven to comparator b.
- `busy`  out  1  high while in SEARCH.
- `done`  out  1  one-cycle pulse; `result` is valid from this cycle.
- `result`  out  WIDTH  recovered target; held until the next accepted start.
- `err`  out  1  sticky flag-protocol error for the current or last search.

## Operation
- States: IDLE, SEARCH, DONE. Internal bit index `idx` is 3 bits.
- IDLE: `trial`=0, `busy`=0. With `start`=1 the block moves to SEARCH, sets `trial`=8'h80 and `idx`=7, clears `err`, and sets `busy`=1.
- SEARCH: the comparator is combinational, so the flags for the current `trial` are sampled in the same cycle.
  - `gt`, or `eq` with early exit disabled: keep bit `idx`.
  - `lt`: clear bit `idx`.
  - If `idx`>0: set bit `idx-1`, then `idx`-=1.
  - If `idx`==0: latch the final value into `result` and go to DONE.
- Flag check: if the flags are not exactly one-hot, set `err` and treat the step as `lt`.
- DONE: `done`=1 and `busy`=0 for one cycle, `trial` returns to 0, then the block returns to IDLE.
- `start` while not in IDLE is ignored. `start` held high re-launches from IDLE on the cycle after DONE.

## Timing
- Reset values: `trial`=0, `result`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- Start accepted at edge 0 means `trial`=0x80 is presented in cycle 1.
- One compare per cycle; 8 compares occupy cycles 1..8.
- `done` is high in cycle 9 (full search).
- Early exit (macro on): an `eq` in compare cycle k gives `done` in cycle k+1 and `result`=current `trial`.
- Minimum start-to-start spacing is 10 cycles (full search).
- Reset asserted mid-search: next cycle is IDLE with all outputs at reset values, and no `done` is produced.
- `result` is not modified by an aborted search.

## Configuration
- `SAR_EARLY_EXIT_EN` defined: `eq` in SEARCH immediately latches `result`=`trial` and goes to DONE, giving variable latency of 2..9 cycles.
- `SAR_EARLY_EXIT_EN` undefined: `eq` is treated as `gt`, every search takes exactly 8 compares (`done` always in cycle 9), and the final `result` is identical.

## Structure
- Shared package/include holds:
  - state encodings `ST_IDLE`=2'd0, `ST_SEARCH`=2'd1, `ST_DONE`=2'd2;
  - the default width constant 8;
  - the initial trial constant 8'h80.
- One natural sub-module, `sar_step`: combinational next-trial logic taking (`trial`, `idx`, `gt`, `lt`, `eq`) and producing (`next_trial`, `flag_err`).
- The FSM and registers live in the top module.

## Test plan
- Target 0x00, macro off: trials are 80,40,20,10,08,04,02,01 → `done` in cycle 9, `result`=0x00, `err`=0.
- Target 0xFF, macro off: trials are 80,C0,E0,F0,F8,FC,FE,FF → `result`=0xFF, `done` in cycle 9.
- Target 0x80, macro on: `eq` in cycle 1 → `done` in cycle 2, `result`=0x80. Same target with macro off → `done` in cycle 9, `result`=0x80.
- Target 0x5A with `start` pulsed again in cycles 3 and 5: both extra pulses are ignored, `result`=0x5A, and exactly one `done`.
- Flags forced to gt=lt=1 in compare cycle 4: `err`=1 and stays set through DONE; the next `start` clears it.
- `rst` asserted in cycle 5 of a search for 0x33 with a prior `result`=0x5A: the next cycle shows IDLE, `trial`=0, `busy`=0, no `done`, and `result` remains 0x5A.
